alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 116 +++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// Single-slot ALU issue stage: operand fetch with result forwarding, external ALU drive,
// one-cycle writeback into a flop-based register file, and a retired-writeback counter.
module alu_issue #(
  parameter int N  = 16,
  parameter int R  = 16,
  parameter int AW = 4,
  parameter int C  = 6,
  parameter int S  = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [C-1:0]  in_opcode,
  input  logic [AW-1:0] in_dst,
  input  logic [AW-1:0] in_srca,
  input  logic [AW-1:0] in_srcb,
  input  logic [S-1:0]  in_shift,
  input  logic [N-1:0]  in_imm,
  input  logic          stall,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [N-1:0]  ld_data,
  output logic [C-1:0]  alu_opcode,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic [S-1:0]  alu_shift,
  input  logic [N-1:0]  alu_y,
  output logic          wb_valid,
  output logic [AW-1:0] wb_addr,
  output logic [N-1:0]  wb_data,
  output logic [15:0]   retire_cnt
);

  logic [N-1:0]  rf_q [R];
  logic          valid_reg;
  logic [C-1:0]  opcode_reg;
  logic [AW-1:0] dst_reg;
  logic [N-1:0]  a_reg, b_reg;
  logic [S-1:0]  shift_reg;
  logic [15:0]   cnt_reg;

  logic          imm_op, fwd_ok;
  logic [N-1:0]  a_next, b_next;

  // Register file entries; writeback takes priority over the external load port.
  genvar gi;
  generate
    for (gi = 0; gi < R; gi++) begin : g_rf
      logic [N-1:0] entry_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg <= '0;
        end else if (wb_valid && (wb_addr == AW'(gi))) begin
          entry_reg <= alu_y;
        end else if (ld_en && (ld_addr == AW'(gi))) begin
          entry_reg <= ld_data;
        end
      end
      assign rf_q[gi] = entry_reg;
    end
  endgenerate

  assign in_ready = !stall;
  assign imm_op   = in_opcode inside {C'(2), C'(4), C'(6), C'(8), C'(10),
                                      C'(12), C'(16), C'(18), C'(20)};
  // The instruction in the issue slot writes back on the same edge, so take its result.
  assign fwd_ok   = valid_reg && (opcode_reg != '0);

  always_comb begin
    a_next = rf_q[in_srca];
    b_next = rf_q[in_srcb];
    if (fwd_ok && (dst_reg == in_srca)) a_next = alu_y;
    if (fwd_ok && (dst_reg == in_srcb)) b_next = alu_y;
    if (imm_op) a_next = in_imm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg  <= 1'b0;
      opcode_reg <= '0;
      dst_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      shift_reg  <= '0;
    end else if (!stall) begin
      valid_reg <= in_valid;
      if (in_valid) begin
        opcode_reg <= in_opcode;
        dst_reg    <= in_dst;
        a_reg      <= a_next;
        b_reg      <= b_next;
        shift_reg  <= in_shift;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (wb_valid) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign alu_opcode = valid_reg ? opcode_reg : '0;
  assign alu_a      = valid_reg ? a_reg      : '0;
  assign alu_b      = valid_reg ? b_reg      : '0;
  assign alu_shift  = valid_reg ? shift_reg  : '0;

  assign wb_valid   = valid_reg && !stall && (opcode_reg != '0);
  assign wb_addr    = dst_reg;
  assign wb_data    = alu_y;
  assign retire_cnt = cnt_reg;

endmodule
